multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Moore FSM that sequences the 32-bit multicycle MIPS datapath.
- Decodes op_i and funct_i from the instruction register.
- Produces every datapath control strobe: PC enable, memory and IR write, register-file write, and the ALU operand and function selects.
- Sits beside the datapath; the only feedback it takes is the ALU zero flag.

Parameters:
- OP_WIDTH, 6, opcode and funct field width.
- STATE_WIDTH, 4, state register width; 12 states are used.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- op_i  in  6  Instr[31:26]
- funct_i  in  6  Instr[5:0]
- zero_i  in  1  ALU zero flag, combinational from the current ALUResult
- PCen  out  1  PC register enable, equal to PCWrite | (Branch & zero_i)
- IorD  out  1  0 = address from PC, 1 = address from ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register enable
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALUOut, 1 = data register
- RegWrite  out  1  register-file write enable
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- PCsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target; bit 0 drives the datapath's current 1-bit PC mux
- illegal_op_o  out  1  unsupported opcode or funct detected
- state_o  out  4  current state, for debug

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high; it forces the state to FETCH.
- Outputs during reset: while reset=1, PCen, IRWrite, MemWrite, RegWrite and illegal_op_o are forced to 0. All other outputs take their FETCH values.
- Reset mid-instruction aborts it; no write strobe is emitted after reset asserts.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
- Unused codes 12–15 return to FETCH on the next clock and drive all outputs to 0.
- Output defaults: every output is 0 unless a state lists it. Outputs are combinational from state; PCen also depends on zero_i.
- ALUOp is internal: 00 → add, 01 → sub, 10 → decode from funct_i.
- Per-state outputs and transitions:
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCsrc=00, IRWrite=1, PCWrite=1. Next: DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next by op_i: 0x23/0x2B → MEMADR, 0x00 → EXECUTE, 0x04 → BRANCH, 0x08 → ADDIEXEC, 0x02 → JUMP (see the optional feature), anything else → FETCH with illegal_op_o=1 during DECODE.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: op 0x23 → MEMRD, otherwise → MEMWR.
  - MEMRD: IorD=1. Next: MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
  - MEMWR: IorD=1, MemWrite=1. Next: FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCsrc=01, Branch=1. Next: FETCH.
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
  - JUMP: PCsrc=10, PCWrite=1. Next: FETCH.
- Funct decode when ALUOp=10: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
- Illegal funct: any other funct gives ALUControl=010 and illegal_op_o=1 during EXECUTE. ALUWB still occurs.
- Cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Illegal opcode takes 2.
- zero_i matters only in BRANCH; it is ignored in every other state.

Optional Feature:
- Macro: MCU_JUMP_EN.
- Defined: opcode 0x02 goes DECODE → JUMP → FETCH as above.
- Undefined: opcode 0x02 is treated as illegal (DECODE → FETCH, illegal_op_o=1); the JUMP state and PCsrc=10 are never produced; state code 11 behaves as an unused code.

Test Plan:
- Reset: assert reset asynchronously mid-cycle → state_o=0 immediately; PCen=IRWrite=MemWrite=RegWrite=0 while reset=1. Release reset → the next cycle shows PCen=1, IRWrite=1, ALUSrcB=01.
- lw: op=0x23 → state_o sequence 0,1,2,3,4,0. MEMRD has IorD=1. MEMWB has RegWrite=1, MemtoReg=1, RegDst=0.
- R-type sub: op=0x00, funct=0x22 → sequence 0,1,6,7,0; ALUControl=110 in EXECUTE; RegDst=1 in ALUWB. Repeat with funct=0x3F → illegal_op_o=1 in EXECUTE and ALUControl=010.
- beq: op=0x04 with zero_i=1 → PCen=1 and PCsrc=01 in BRANCH. With zero_i=0 → PCen=0. ALUControl=110 in both cases.
- sw plus illegal opcode: op=0x2B → sequence 0,1,2,5,0 with MemWrite=1 only in state 5. op=0x3F → sequence 0,1,0 with illegal_op_o=1 for exactly one cycle.
- Jump (MCU_JUMP_EN defined): op=0x02 → sequence 0,1,11,0; PCsrc=10 and PCen=1 in state 11. Undefined build: op=0x02 → sequence 0,1,0 with illegal_op_o=1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - Moore control FSM for the multicycle MIPS datapath (optional jump: MCU_JUMP_EN)
module multicycle_control_unit #(
  parameter int OP_WIDTH    = 6,
  parameter int STATE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OP_WIDTH-1:0]    op_i,
  input  logic [OP_WIDTH-1:0]    funct_i,
  input  logic                   zero_i,
  output logic                   PCen,
  output logic                   IorD,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   RegDst,
  output logic                   MemtoReg,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [2:0]             ALUControl,
  output logic [1:0]             PCsrc,
  output logic                   illegal_op_o,
  output logic [STATE_WIDTH-1:0] state_o
);

  typedef enum logic [STATE_WIDTH-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_WIDTH-1:0] OP_J     = 6'h02;
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_WIDTH-1:0] OP_LW    = 6'h23;
  localparam logic [OP_WIDTH-1:0] OP_SW    = 6'h2B;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  w_alu_op;
  logic        w_alu_en;
  logic        w_pc_write;
  logic        w_branch;
  logic        w_irwrite;
  logic        w_memwrite;
  logic        w_regwrite;
  logic        w_illegal;
  logic [2:0]  w_funct_ctl;
  logic        w_funct_legal;

  // State register; reset parks the machine in FETCH regardless of the clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  // Next-state selection; DECODE dispatches on the opcode, unused codes recover to FETCH
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:  w_next = DECODE;
      DECODE: begin
        case (op_i)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = EXECUTE;
          OP_BEQ:       w_next = BRANCH;
          OP_ADDI:      w_next = ADDIEXEC;
`ifdef MCU_JUMP_EN
          OP_J:         w_next = JUMP;
`endif
          default:      w_next = FETCH;
        endcase
      end
      MEMADR:   w_next = (op_i == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    w_next = MEMWB;
      EXECUTE:  w_next = ALUWB;
      ADDIEXEC: w_next = ADDIWB;
      default:  w_next = FETCH;
    endcase
  end

  // R-type funct decode; an unknown funct falls back to add and is flagged
  always_comb begin
    w_funct_ctl   = 3'b010;
    w_funct_legal = 1'b1;
    case (funct_i)
      6'h20:   w_funct_ctl = 3'b010;
      6'h22:   w_funct_ctl = 3'b110;
      6'h24:   w_funct_ctl = 3'b000;
      6'h25:   w_funct_ctl = 3'b001;
      6'h2A:   w_funct_ctl = 3'b111;
      default: w_funct_legal = 1'b0;
    endcase
  end

  // Per-state control strobes; everything not listed for a state stays 0
  always_comb begin
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCsrc      = 2'b00;
    w_alu_op   = 2'b00;
    w_alu_en   = 1'b1;
    w_pc_write = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      FETCH: begin
        ALUSrcB    = 2'b01;
        w_irwrite  = 1'b1;
        w_pc_write = 1'b1;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (op_i)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI: w_illegal = 1'b0;
`ifdef MCU_JUMP_EN
          OP_J:    w_illegal = 1'b0;
`endif
          default: w_illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD:  IorD = 1'b1;
      MEMWB: begin
        MemtoReg   = 1'b1;
        w_regwrite = 1'b1;
      end
      MEMWR: begin
        IorD       = 1'b1;
        w_memwrite = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA   = 1'b1;
        w_alu_op  = 2'b10;
        w_illegal = ~w_funct_legal;
      end
      ALUWB: begin
        RegDst     = 1'b1;
        w_regwrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        w_alu_op = 2'b01;
        PCsrc    = 2'b01;
        w_branch = 1'b1;
      end
      ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: w_regwrite = 1'b1;
`ifdef MCU_JUMP_EN
      JUMP: begin
        PCsrc      = 2'b10;
        w_pc_write = 1'b1;
      end
`endif
      default: w_alu_en = 1'b0;
    endcase
  end

  // ALU function select from the internal ALUOp
  always_comb begin
    ALUControl = 3'b000;
    if (w_alu_en) begin
      case (w_alu_op)
        2'b01:   ALUControl = 3'b110;
        2'b10:   ALUControl = w_funct_ctl;
        default: ALUControl = 3'b010;
      endcase
    end
  end

  // Write strobes and the illegal flag are held low while reset is asserted
  assign PCen         = ~reset & (w_pc_write | (w_branch & zero_i));
  assign IRWrite      = ~reset & w_irwrite;
  assign MemWrite     = ~reset & w_memwrite;
  assign RegWrite     = ~reset & w_regwrite;
  assign illegal_op_o = ~reset & w_illegal;
  assign state_o      = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op_i;
  logic [5:0] funct_i;
  logic       zero_i;
  logic       PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCsrc;
  logic       illegal_op_o;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .op_i(op_i), .funct_i(funct_i), .zero_i(zero_i),
    .PCen(PCen), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCsrc(PCsrc),
    .illegal_op_o(illegal_op_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // {PCen,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB[2],ALUControl[3],PCsrc[2],illegal}
  logic [15:0] obs;
  assign obs = {PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUControl, PCsrc, illegal_op_o};

  localparam logic [15:0] RESET_VEC = {8'b0, 2'b01, 3'b010, 2'b00, 1'b0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit jump_en();
`ifdef MCU_JUMP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit op_supported(input logic [5:0] op);
    return (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) || (op == 6'h04) ||
           (op == 6'h08) || (jump_en() && op == 6'h02);
  endfunction

  // Reference: ALU operation requested by an R-type funct, and whether it is known
  function automatic logic [3:0] funct_model(input logic [5:0] fn);
    case (fn)
      6'h20:   return {1'b1, 3'b010};
      6'h22:   return {1'b1, 3'b110};
      6'h24:   return {1'b1, 3'b000};
      6'h25:   return {1'b1, 3'b001};
      6'h2A:   return {1'b1, 3'b111};
      default: return {1'b0, 3'b010};
    endcase
  endfunction

  // Reference: control word the datapath needs in a given step of an instruction
  function automatic logic [15:0] exp_vec(input int st, input logic [5:0] op,
                                          input logic [5:0] fn, input logic z);
    logic pcen = 0, iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, ill = 0;
    logic [1:0] sb = 0, pcs = 0;
    logic [2:0] alu = 3'b010;
    logic [3:0] fm;
    case (st)
      0:  begin pcen = 1; irw = 1; sb = 2'b01; end
      1:  begin sb = 2'b11; ill = !op_supported(op); end
      2:  begin sa = 1; sb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin sa = 1; fm = funct_model(fn); alu = fm[2:0]; ill = !fm[3]; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; alu = 3'b110; pcs = 2'b01; pcen = z; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcen = 1; end
      default: ;
    endcase
    return {pcen, iord, mw, irw, rd, m2r, rw, sa, sb, alu, pcs, ill};
  endfunction

  // ALU select is only specified where a state names its ALU operation
  function automatic logic [15:0] care_mask(input int st);
    if (st == 0 || st == 1 || st == 2 || st == 6 || st == 8 || st == 9) return 16'hFFFF;
    return 16'hFFC7;
  endfunction

  task automatic reset_checks(input string tag);
    check_eq({tag, " state"}, {28'b0, state_o}, 32'd0);
    check_eq({tag, " outs"}, {16'b0, obs}, {16'b0, RESET_VEC});
  endtask

  // Abort the current instruction with an asynchronous reset mid-cycle
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 reset_checks("async reset");
    @(negedge clk);
    #1 reset_checks("held reset");
    reset = 1'b0;
  endtask

  // Run one instruction; zmode 0/1 fixes zero_i, 2 randomizes it each cycle
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int abort_at);
    int seq[$];
    seq = {0, 1};
    case (op)
      6'h23: seq = {0, 1, 2, 3, 4};
      6'h2B: seq = {0, 1, 2, 5};
      6'h00: seq = {0, 1, 6, 7};
      6'h04: seq = {0, 1, 8};
      6'h08: seq = {0, 1, 9, 10};
      6'h02: if (jump_en()) seq = {0, 1, 11};
      default: ;
    endcase
    op_i    = op;
    funct_i = fn;
    for (int i = 0; i < seq.size(); i++) begin
      zero_i = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      check_eq($sformatf("state op=%02h step%0d", op, i), {28'b0, state_o}, 32'(seq[i]));
      check_eq($sformatf("outs op=%02h fn=%02h st%0d z=%0d", op, fn, seq[i], zero_i),
               {16'b0, obs & care_mask(seq[i])},
               {16'b0, exp_vec(seq[i], op, fn, zero_i) & care_mask(seq[i])});
      if (i == abort_at) begin
        do_reset();
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [5:0] ops[6];
    logic [5:0] fns[5];
    logic [5:0] op, fn;
    ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    reset = 1'b1; op_i = 6'h0; funct_i = 6'h0; zero_i = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_checks("power-on reset");
    reset = 1'b0;

    // Directed instructions
    run_instr(6'h23, 6'h00, 2, -1);
    run_instr(6'h00, 6'h22, 2, -1);
    run_instr(6'h00, 6'h3F, 2, -1);
    run_instr(6'h04, 6'h00, 1, -1);
    run_instr(6'h04, 6'h00, 0, -1);
    run_instr(6'h2B, 6'h00, 2, -1);
    run_instr(6'h3F, 6'h00, 2, -1);
    run_instr(6'h02, 6'h00, 2, -1);
    run_instr(6'h08, 6'h00, 2, -1);
    run_instr(6'h2B, 6'h00, 2, 3);
    run_instr(6'h23, 6'h00, 2, 2);

    // Randomized instruction stream with occasional aborts
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        6:       op = 6'($urandom_range(0, 63));
        7:       op = 6'h00;
        default: op = ops[$urandom_range(0, 5)];
      endcase
      fn = ($urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
      run_instr(op, fn, 2, ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
